// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle RV32I core: walks the shared ALU and unified memory
// through fetch/decode/execute/memory/writeback and traps on a stalled memory access.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10;
  localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_FUNCT = 2'b10;
  localparam logic [1:0] R_ALUOUT = 2'b00, R_MEM = 2'b01, R_ALU = 2'b10, R_IMM = 2'b11;

  // Trap fires on the cycle that would be the TIMEOUT_CYCLES-th consecutive stall.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       wait_hit;
  ctrl_t      ctrl;

  assign in_wait  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign wait_hit = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Counter is zero in every non-wait state, so entry into a wait state starts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    wait_cnt <= '0;
    else if (!in_wait || mem_ready) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         mem_err <= 1'b0;
    else if (wait_hit) mem_err <= 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (wait_hit)       state_nxt = S_TRAP;
        else if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default:           state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  state_nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (wait_hit)       state_nxt = S_TRAP;
        else if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWRITE: begin
        if (wait_hit)       state_nxt = S_TRAP;
        else if (mem_ready) state_nxt = S_FETCH;
      end
      S_MEMWB:  state_nxt = S_FETCH;
      S_EXECR:  state_nxt = S_ALUWB;
      S_EXECI:  state_nxt = S_ALUWB;
      S_AUIPC:  state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JAL:    state_nxt = S_ALUWB;
      S_LUI:    state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_TRAP;
    endcase
  end

  // Output decode
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.adr_src  = 1'b0;
        ctrl.alu_src_a = A_PC;
        ctrl.alu_op    = OP_ADD;
        if (mem_ready) begin
          ctrl.ir_write   = 1'b1;
          ctrl.pc_write   = 1'b1;
          ctrl.alu_src_b  = B_FOUR;
          ctrl.result_src = R_ALU;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = A_OLDPC;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = OP_ADD;
        unique case (opcode)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
          OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: ctrl.illegal_op = 1'b0;
          default:                             ctrl.illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = OP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.adr_src  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = R_MEM;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_RS2;
        ctrl.alu_op    = OP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = OP_FUNCT;
      end
      S_AUIPC: begin
        ctrl.alu_src_a = A_OLDPC;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = OP_ADD;
      end
      S_ALUWB: begin
        ctrl.result_src = R_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = A_RS1;
        ctrl.alu_src_b  = B_RS2;
        ctrl.alu_op     = OP_SUB;
        ctrl.result_src = R_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC takes the DECODE-time target held in ALUOut while the ALU forms oldPC+4.
        ctrl.alu_src_a  = A_OLDPC;
        ctrl.alu_src_b  = B_FOUR;
        ctrl.alu_op     = OP_ADD;
        ctrl.result_src = R_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      S_LUI: begin
        ctrl.result_src = R_IMM;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
  assign ir_write   = ctrl.ir_write;
  assign adr_src    = ctrl.adr_src;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = ctrl.illegal_op;
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state walks, memory stalls, branch/JAL/LUI,
// illegal opcode, timeout trap and asynchronous reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       instr_done, illegal_op, mem_err;
  logic [3:0] state_o;
  logic [16:0] out_bus;

  int tests = 0;
  int fails = 0;

  multicycle_control #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err),
    .state_o(state_o)
  );

  assign out_bus = {pc_en, ir_write, adr_src, mem_read, mem_write, reg_write, alu_src_a,
                    alu_src_b, alu_op, result_src, instr_done, illegal_op, mem_err};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("reset_state", state_o, 4'd0);
    chk("reset_outs", out_bus, 17'h0);
    reset = 1'b0;
    #1;
    chk("idle_state", state_o, 4'd0);
    tick();

    chk("r_fetch", state_o, 4'd1);
    chk("r_fetch_ctl", {mem_read, adr_src, ir_write, pc_en, alu_src_b, result_src}, 8'b1011_10_10);
    chk("r_fetch_rw", reg_write, 1'b0);
    tick();
    chk("r_decode", state_o, 4'd2);
    chk("r_decode_alu", {alu_src_a, alu_src_b, alu_op}, 6'b01_01_00);
    chk("r_decode_wr", {reg_write, instr_done, illegal_op}, 3'b000);
    tick();
    chk("r_execr", state_o, 4'd7);
    chk("r_execr_alu", {alu_src_a, alu_src_b, alu_op}, 6'b10_00_10);
    chk("r_execr_wr", {reg_write, instr_done}, 2'b00);
    tick();
    chk("r_aluwb", state_o, 4'd9);
    chk("r_aluwb_wr", {reg_write, instr_done, result_src}, 4'b11_00);
    tick();
    chk("r_back_fetch", state_o, 4'd1);

    opcode = 7'b0000011;
    tick();
    chk("ld_decode", state_o, 4'd2);
    tick();
    chk("ld_memadr", state_o, 4'd3);
    chk("ld_memadr_alu", {alu_src_a, alu_src_b, alu_op}, 6'b10_01_00);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("ld_memread", state_o, 4'd4);
    chk("ld_memread_ctl", {mem_read, adr_src, instr_done, reg_write}, 4'b1100);
    tick(); tick(); tick();
    chk("ld_stall3", state_o, 4'd4);
    mem_ready = 1'b1;
    tick();
    chk("ld_memwb", state_o, 4'd5);
    chk("ld_memwb_ctl", {result_src, reg_write, instr_done}, 4'b01_11);
    tick();
    chk("ld_back_fetch", state_o, 4'd1);

    opcode = 7'b1100011; zero = 1'b1;
    tick(); tick();
    chk("br_state", state_o, 4'd10);
    chk("br_taken", pc_en, 1'b1);
    chk("br_ctl", {alu_src_a, alu_src_b, alu_op, reg_write, instr_done}, 8'b10_00_01_0_1);
    zero = 1'b0;
    #1;
    chk("br_not_taken", pc_en, 1'b0);
    tick();
    chk("br_back_fetch", state_o, 4'd1);

    opcode = 7'b1101111;
    tick(); tick();
    chk("jal_state", state_o, 4'd11);
    chk("jal_ctl", {pc_en, alu_src_a, alu_src_b, reg_write}, 6'b1_01_10_0);
    tick();
    chk("jal_aluwb", {state_o, reg_write, instr_done}, 6'b1001_11);
    tick();
    opcode = 7'b0110111;
    tick(); tick();
    chk("lui_state", state_o, 4'd12);
    chk("lui_ctl", {result_src, reg_write, instr_done}, 4'b11_11);
    tick();
    chk("lui_back_fetch", state_o, 4'd1);

    opcode = 7'b1111111;
    tick();
    chk("ill_decode", {state_o, illegal_op}, 5'b0010_1);
    chk("ill_no_write", {instr_done, reg_write, mem_write}, 3'b000);
    tick();
    chk("ill_fetch", {state_o, illegal_op, instr_done}, 6'b0001_00);

    mem_ready = 1'b0; opcode = 7'b0110111;
    for (int i = 0; i < 14; i++) tick();
    chk("nt_still_fetch", state_o, 4'd1);
    mem_ready = 1'b1;
    #1;
    chk("nt_ir_write", ir_write, 1'b1);
    tick();
    chk("nt_decode", {state_o, mem_err}, 5'b0010_0);
    tick(); tick();

    opcode = 7'b0100011;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    chk("st_memwrite", {state_o, mem_write, adr_src, instr_done}, 7'b0110_110);
    tick();
    chk("st_stall", {state_o, mem_write}, 5'b0110_1);
    reset = 1'b1;
    #1;
    chk("st_reset_state", state_o, 4'd0);
    chk("st_reset_outs", out_bus, 17'h0);

    tick();
    reset = 1'b0;
    tick();
    chk("to_fetch", state_o, 4'd1);
    for (int i = 0; i < 14; i++) tick();
    chk("to_pre_trap", {state_o, mem_err}, 5'b0001_0);
    tick();
    chk("to_trap", state_o, 4'd15);
    chk("to_trap_outs", out_bus, 17'h1);
    mem_ready = 1'b1;
    tick(); tick();
    chk("to_absorb", {state_o, mem_err}, 5'b1111_1);
    reset = 1'b1;
    #1;
    chk("to_reset_clears", {state_o, mem_err}, 5'b0000_0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
